// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_t   : sequencer states (IDLE, RUN)
//   cnt_width : bit-counter width for a given operand width
package sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

  // Counter must index bits 0..w-1. Keep at least one bit for tiny widths.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : unsigned'($clog2(w));
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// Combinational full subtractor built from two half-subtractor stages.
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in
//   d     : difference bit a - b - bin
//   bout  : borrow out
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // First stage: a - b
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // Second stage: (a - b) - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Df = A - B (mod 2^WIDTH), Bo = 1 iff A < B.
// One bit per clock, LSB first, borrow carried in a flop between bits.
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, sampled only while idle
//   A, B     : operands, captured on the accepting edge
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when Df/Bo are updated
//   Df, Bo   : difference and final borrow, held until the next completion
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Df,
  output logic             Bo
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic             d;
  logic             bout;

  full_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  // Result fills from the MSB side so bit 0 lands at position 0 after WIDTH shifts.
  assign res_next = {d, res[WIDTH-1:1]};

  // Sequencer, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Df     <= '0;
      Bo     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bout;
          res    <= res_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            Df    <= res_next;
            Bo    <= bout;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=16 instances).
module tb_serial_subtractor;

  logic        clk;
  logic        rst;

  logic        start8;
  logic [7:0]  a8, b8, df8;
  logic        busy8, done8, bo8;

  logic        start16;
  logic [15:0] a16, b16, df16;
  logic        busy16, done16, bo16;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Df(df8), .Bo(bo8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .Df(df16), .Bo(bo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one 8-bit op from an aligned point (#1 after a rising edge).
  // lat: cycles from accepting edge to done; nbusy: busy samples before done;
  // one_shot: done low on the following cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int nbusy,
                      output logic [7:0] df, output logic bo, output logic one_shot);
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b;
    lat = 0; nbusy = 0;
    while (!done8 && lat < 40) begin
      if (busy8) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    df = df8; bo = bo8;
    @(posedge clk); #1;
    one_shot = !done8;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [15:0] df, output logic bo,
                       output logic one_shot);
    start16 = 1'b1; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    df = df16; bo = bo16;
    @(posedge clk); #1;
    one_shot = !done16;
  endtask

  task automatic test_reset();
    int lat, nb;
    logic [7:0] df;
    logic bo, os;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, bo8, df8} !== 11'd0) begin
      failures++;
      $display("FAIL reset_values got=%h want=0", {busy8, done8, bo8, df8});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Leave a nonzero result behind so the mid-run reset has something to clear.
    run8(8'd200, 8'd55, lat, nb, df, bo, os);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, bo8, df8} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid_run got=%h want=0", {busy8, done8, bo8, df8});
    end
    @(posedge clk); #1 rst = 1'b0;
    run8(8'd3, 8'd1, lat, nb, df, bo, os);
    checks++;
    if ({bo, df} !== {1'b0, 8'd2} || lat != 8) begin
      failures++;
      $display("FAIL reset_recover got=%b/%h lat=%0d want=0/02 lat=8", bo, df, lat);
    end
  endtask

  task automatic test_no_borrow();
    int lat, nb;
    logic [7:0] df;
    logic bo, os;
    run8(8'd200, 8'd55, lat, nb, df, bo, os);
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL nb_latency got=%0d want=8", lat);
    end
    checks++;
    if (nb != 8) begin
      failures++;
      $display("FAIL nb_busy_cycles got=%0d want=8", nb);
    end
    checks++;
    if ({bo, df} !== {1'b0, 8'd145}) begin
      failures++;
      $display("FAIL nb_result got=%b/%0d want=0/145", bo, df);
    end
    checks++;
    if (!os) begin
      failures++;
      $display("FAIL nb_done_width got=2+ want=1");
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'd5, 8'd0, 8'hFF, 8'h00};
    logic [7:0] vb [4] = '{8'd9, 8'd1, 8'hFF, 8'h00};
    logic [8:0] exp [4] = '{{1'b1, 8'hFC}, {1'b1, 8'hFF}, 9'd0, 9'd0};
    int lat, nb;
    logic [7:0] df;
    logic bo, os;
    for (int i = 0; i < 4; i++) begin
      run8(va[i], vb[i], lat, nb, df, bo, os);
      checks++;
      if ({bo, df} !== exp[i] || lat != 8) begin
        failures++;
        $display("FAIL vector%0d got=%b/%h lat=%0d want=%h lat=8", i, bo, df, lat, exp[i]);
      end
    end
  endtask

  task automatic test_handshake();
    int t;
    // Start pulses during RUN with different operands must be ignored.
    start8 = 1'b1; a8 = 8'h30; b8 = 8'h10;
    @(posedge clk); #1;
    start8 = 1'b0;
    t = 0;
    while (!done8 && t < 40) begin
      if (t == 3 || t == 5) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h80; end
      else start8 = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    start8 = 1'b0;
    checks++;
    if (df8 !== 8'h20 || bo8 !== 1'b0 || t != 8) begin
      failures++;
      $display("FAIL hs_ignore got=%b/%h t=%0d want=0/20 t=8", bo8, df8, t);
    end
    @(posedge clk); #1;
    // Start held high: second op accepted in the done cycle.
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd3;
    @(posedge clk); #1;
    a8 = 8'd20; b8 = 8'd5;
    t = 0;
    while (!done8 && t < 40) begin @(posedge clk); #1; t++; end
    checks++;
    if (df8 !== 8'd7 || t != 8) begin
      failures++;
      $display("FAIL hs_first got=%0d t=%0d want=7 t=8", df8, t);
    end
    t = 0;
    @(posedge clk); #1;
    t++;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL hs_accept_in_done busy=%b done=%b want busy=1 done=0", busy8, done8);
    end
    while (!done8 && t < 40) begin @(posedge clk); #1; t++; end
    checks++;
    if (df8 !== 8'd15 || t != 9) begin
      failures++;
      $display("FAIL hs_back_to_back got=%0d spacing=%0d want=15 spacing=9", df8, t);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, nb;
    logic [7:0]  a, b, df;
    logic [15:0] c, e, df16_v;
    logic [8:0]  exp8;
    logic [16:0] exp16;
    logic bo, os;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      exp8 = {1'b0, a} - {1'b0, b};
      run8(a, b, lat, nb, df, bo, os);
      checks++;
      if ({bo, df} !== exp8 || lat != 8 || !os) begin
        failures++;
        $display("FAIL rand8 a=%h b=%h got=%b/%h lat=%0d one=%b want=%h lat=8 one=1",
                 a, b, bo, df, lat, os, exp8);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      c = 16'($urandom); e = 16'($urandom);
      if (i == 0) begin c = 16'd0; e = 16'd1; end
      exp16 = {1'b0, c} - {1'b0, e};
      run16(c, e, lat, df16_v, bo, os);
      checks++;
      if ({bo, df16_v} !== exp16 || lat != 16 || !os) begin
        failures++;
        $display("FAIL rand16 a=%h b=%h got=%b/%h lat=%0d one=%b want=%h lat=16 one=1",
                 c, e, bo, df16_v, lat, os, exp16);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    @(posedge clk); #1;
    test_reset();
    test_no_borrow();
    test_vectors();
    test_handshake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
